// File: rtl/filtr_sample_sched.sv
// Sample-rate scheduler in front of filtr_top: divides clk to the sample tick,
// double-buffers source samples, strobes the filter and captures its result.
module filtr_sample_sched #(
  parameter int unsigned DATA_SIZE  = 25,
  parameter int unsigned CLK_DIV    = 25000,
  parameter int unsigned STROBE_LEN = 3,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [DATA_SIZE-2:0] src_data,
  input  logic                 src_valid,
  output logic [DATA_SIZE-2:0] filt_data_in,
  output logic                 filt_sample,
  input  logic                 filt_done,
  input  logic [DATA_SIZE-2:0] filt_data_out,
  output logic [DATA_SIZE-2:0] out_data,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 overrun,
  output logic                 underrun,
  output logic                 timeout_err,
  input  logic                 clr_err,
  output logic [15:0]          sample_cnt
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned STB_W = (STROBE_LEN > 1) ? $clog2(STROBE_LEN) : 1;
  localparam int unsigned TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(STROBE_LEN - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_STROBE  = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_CAPTURE = 2'd3;

  logic [1:0]           state;
  logic [DIV_W-1:0]     div_cnt;
  logic [STB_W-1:0]     stb_cnt;
  logic [TO_W-1:0]      to_cnt;
  logic [DATA_SIZE-2:0] hold_reg;
  logic                 pending;
  logic                 tick;
  logic                 consume;
  logic                 overrun_set;
  logic                 underrun_set;
  logic                 timeout_set;

  // Tick and event decode
  always_comb begin
    tick         = enable && (div_cnt == DIV_LAST);
    consume      = (state == S_IDLE) && tick && pending;
    overrun_set  = src_valid && pending && !consume;
    underrun_set = tick && ((state != S_IDLE) || !pending);
    timeout_set  = (state == S_WAIT) && !filt_done && (to_cnt == TO_LAST);
    busy         = (state != S_IDLE);
  end

  // Sample-rate divider, held at zero while disabled
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (!enable || (div_cnt == DIV_LAST)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Input holding register; a new sample in the consuming cycle keeps pending set
  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_reg <= '0;
      pending  <= 1'b0;
    end else if (src_valid) begin
      hold_reg <= src_data;
      pending  <= 1'b1;
    end else if (consume) begin
      pending  <= 1'b0;
    end
  end

  // Transaction FSM: strobe the filter, wait for done, capture the result.
  // The result is registered on the WAIT->CAPTURE transition so that out_data and
  // out_valid appear one cycle after done; CAPTURE is the cycle out_valid is high.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      stb_cnt      <= '0;
      to_cnt       <= '0;
      filt_data_in <= '0;
      filt_sample  <= 1'b0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      sample_cnt   <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (consume) begin
            filt_data_in <= hold_reg;
            filt_sample  <= 1'b1;
            stb_cnt      <= '0;
            state        <= S_STROBE;
          end
        end
        S_STROBE: begin
          if (stb_cnt == STB_LAST) begin
            filt_sample <= 1'b0;
            to_cnt      <= '0;
            state       <= S_WAIT;
          end else begin
            stb_cnt <= stb_cnt + STB_W'(1);
          end
        end
        S_WAIT: begin
          if (filt_done) begin
            out_data   <= filt_data_out;
            out_valid  <= 1'b1;
            sample_cnt <= sample_cnt + 16'd1;
            state      <= S_CAPTURE;
          end else if (to_cnt == TO_LAST) begin
            state <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Sticky error flags; a new event wins over clr_err
  always_ff @(posedge clk) begin
    if (!reset) begin
      overrun     <= 1'b0;
      underrun    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      overrun     <= overrun_set  || (overrun     && !clr_err);
      underrun    <= underrun_set || (underrun    && !clr_err);
      timeout_err <= timeout_set  || (timeout_err && !clr_err);
    end
  end

endmodule

// File: tb/tb_filtr_sample_sched.sv
// Directed bench for filtr_sample_sched with a small filter model that answers
// 5 cycles after the strobe rises, returning data ^ 0x00F0F0.
module tb_filtr_sample_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [23:0] src_data;
  logic        src_valid;
  logic [23:0] filt_data_in;
  logic        filt_sample;
  logic        filt_done;
  logic [23:0] filt_data_out;
  logic [23:0] out_data;
  logic        out_valid;
  logic        busy;
  logic        overrun;
  logic        underrun;
  logic        timeout_err;
  logic        clr_err;
  logic [15:0] sample_cnt;

  int checks = 0;
  int errors = 0;

  filtr_sample_sched #(
    .DATA_SIZE (25),
    .CLK_DIV   (10),
    .STROBE_LEN(3),
    .TIMEOUT   (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .src_data     (src_data),
    .src_valid    (src_valid),
    .filt_data_in (filt_data_in),
    .filt_sample  (filt_sample),
    .filt_done    (filt_done),
    .filt_data_out(filt_data_out),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .busy         (busy),
    .overrun      (overrun),
    .underrun     (underrun),
    .timeout_err  (timeout_err),
    .clr_err      (clr_err),
    .sample_cnt   (sample_cnt)
  );

  always #5 clk = ~clk;

  // Filter model
  logic        prev_smp = 1'b0;
  int          mcnt = 0;
  logic [23:0] mdata = '0;
  bit          mute = 1'b0;

  always @(posedge clk) begin
    prev_smp <= filt_sample;
    if (filt_sample && !prev_smp) begin
      mcnt  <= 5;
      mdata <= filt_data_in;
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
    end
  end

  assign filt_done     = !mute && (mcnt == 1);
  assign filt_data_out = mdata ^ 24'h00F0F0;

  function automatic logic [23:0] samp(input int i);
    logic [23:0] t;
    t = 24'(i) * 24'h01F3A7;
    return t ^ 24'h5A5A5A;
  endfunction

  task automatic send_src(input logic [23:0] d);
    src_data  = d;
    src_valid = 1'b1;
    @(negedge clk);
    src_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; src_valid = 1'b0; src_data = '0; clr_err = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({out_valid, filt_sample, busy, overrun, underrun, timeout_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000",
               {out_valid, filt_sample, busy, overrun, underrun, timeout_err});
    end
    checks++;
    if ({filt_data_in, out_data, sample_cnt} !== 64'h0) begin
      errors++;
      $display("FAIL reset_regs: got %h expected 0", {filt_data_in, out_data, sample_cnt});
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    int n, h, lat;
    send_src(24'h000123);
    enable = 1'b1;
    n = 0;
    while (!filt_sample && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (n !== 10) begin errors++; $display("FAIL nominal_tick_latency: got %0d expected 10", n); end
    checks++;
    if (filt_data_in !== 24'h000123) begin
      errors++; $display("FAIL nominal_data_in: got %h expected 000123", filt_data_in);
    end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL nominal_busy: got %b expected 1", busy); end
    h = 0;
    while (filt_sample && h < 10) begin @(negedge clk); h++; end
    checks++;
    if (h !== 3) begin errors++; $display("FAIL nominal_strobe_len: got %0d expected 3", h); end
    lat = h;
    while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
    enable = 1'b0;
    checks++;
    if (lat !== 6) begin errors++; $display("FAIL nominal_result_latency: got %0d expected 6", lat); end
    checks++;
    if (out_data !== 24'h00F1D3) begin
      errors++; $display("FAIL nominal_out_data: got %h expected 00f1d3", out_data);
    end
    checks++;
    if (sample_cnt !== 16'd1) begin
      errors++; $display("FAIL nominal_sample_cnt: got %0d expected 1", sample_cnt);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL nominal_valid_pulse: got %b expected 00", {out_valid, busy});
    end
    checks++;
    if ({overrun, underrun, timeout_err} !== 3'b000) begin
      errors++; $display("FAIL nominal_flags: got %b expected 000", {overrun, underrun, timeout_err});
    end
  endtask

  task automatic test_overrun();
    int n;
    send_src(24'h00000A);
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_single: got %b expected 0", overrun); end
    send_src(24'h00000B);
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b expected 1", overrun); end
    enable = 1'b1;
    n = 0;
    while (!filt_sample && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (filt_data_in !== 24'h00000B) begin
      errors++; $display("FAIL overrun_data_in: got %h expected 00000b", filt_data_in);
    end
    n = 0;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    enable = 1'b0;
    checks++;
    if (out_data !== 24'h00F0FB || sample_cnt !== 16'd2) begin
      errors++; $display("FAIL overrun_result: got %h/%0d expected 00f0fb/2", out_data, sample_cnt);
    end
    checks++;
    if (underrun !== 1'b0) begin errors++; $display("FAIL overrun_no_underrun: got %b expected 0", underrun); end
    pulse_clr();
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b expected 0", overrun); end
  endtask

  task automatic test_underrun_timeout();
    int n, c;
    bit seen;
    enable = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if ({underrun, filt_sample, busy} !== 3'b100) begin
      errors++; $display("FAIL underrun_idle: got %b expected 100", {underrun, filt_sample, busy});
    end
    enable = 1'b0;
    pulse_clr();
    checks++;
    if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_clear: got %b expected 0", underrun); end
    mute = 1'b1;
    send_src(24'h000055);
    enable = 1'b1;
    n = 0;
    while (!filt_sample && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (n !== 10) begin errors++; $display("FAIL timeout_tick_latency: got %0d expected 10", n); end
    repeat (10) @(negedge clk);
    checks++;
    if ({underrun, busy} !== 2'b11) begin
      errors++; $display("FAIL underrun_busy_tick: got %b expected 11", {underrun, busy});
    end
    enable = 1'b0;
    c = 20; seen = 1'b0;
    while (!timeout_err && c < 60) begin
      @(negedge clk); c++;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (c !== 29) begin errors++; $display("FAIL timeout_cycle: got %0d expected 29", c); end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL timeout_no_valid: got %b expected 0", seen); end
    checks++;
    if ({busy, sample_cnt} !== {1'b0, 16'd2}) begin
      errors++; $display("FAIL timeout_idle: got %b/%0d expected 0/2", busy, sample_cnt);
    end
    mute = 1'b0;
    pulse_clr();
    checks++;
    if ({overrun, underrun, timeout_err} !== 3'b000) begin
      errors++; $display("FAIL timeout_clear: got %b expected 000", {overrun, underrun, timeout_err});
    end
  endtask

  task automatic test_simultaneous();
    int n;
    send_src(24'h000001);
    enable = 1'b1;
    repeat (9) @(negedge clk);
    src_data = 24'h000002; src_valid = 1'b1;
    @(negedge clk);
    src_valid = 1'b0;
    enable = 1'b0;
    checks++;
    if ({filt_sample, overrun} !== 2'b10 || filt_data_in !== 24'h000001) begin
      errors++; $display("FAIL simul_issue: got %b/%h expected 10/000001", {filt_sample, overrun}, filt_data_in);
    end
    n = 0;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (out_data !== 24'h00F0F1) begin errors++; $display("FAIL simul_out1: got %h expected 00f0f1", out_data); end
    enable = 1'b1;
    n = 0;
    while (!filt_sample && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (filt_data_in !== 24'h000002) begin
      errors++; $display("FAIL simul_pending: got %h expected 000002", filt_data_in);
    end
    n = 0;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    enable = 1'b0;
    checks++;
    if (out_data !== 24'h00F0F2 || sample_cnt !== 16'd4) begin
      errors++; $display("FAIL simul_out2: got %h/%0d expected 00f0f2/4", out_data, sample_cnt);
    end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL simul_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_reset_mid_wait();
    int n;
    bit seen;
    send_src(24'h000077);
    enable = 1'b1;
    n = 0;
    while (!filt_sample && n < 40) begin @(negedge clk); n++; end
    enable = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midwait_busy: got %b expected 1", busy); end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checks++;
    if ({out_valid, filt_sample, busy, overrun, underrun, timeout_err} !== 6'b0) begin
      errors++; $display("FAIL midwait_reset_flags: got %b expected 000000",
                         {out_valid, filt_sample, busy, overrun, underrun, timeout_err});
    end
    checks++;
    if ({filt_data_in, out_data, sample_cnt} !== 64'h0) begin
      errors++; $display("FAIL midwait_reset_regs: got %h expected 0", {filt_data_in, out_data, sample_cnt});
    end
    seen = 1'b0;
    repeat (6) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL midwait_no_valid: got %b expected 0", seen); end
    send_src(24'h000099);
    enable = 1'b1;
    n = 0;
    while (!filt_sample && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (filt_data_in !== 24'h000099) begin
      errors++; $display("FAIL midwait_next_data: got %h expected 000099", filt_data_in);
    end
    n = 0;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    enable = 1'b0;
    checks++;
    if (out_data !== 24'h00F069 || sample_cnt !== 16'd1) begin
      errors++; $display("FAIL midwait_next_result: got %h/%0d expected 00f069/1", out_data, sample_cnt);
    end
  endtask

  task automatic test_sweep();
    int n;
    int nvalid;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    nvalid = 0;
    send_src(samp(0));
    enable = 1'b1;
    for (int i = 0; i < 200; i++) begin
      n = 0;
      while (!filt_sample && n < 40) begin @(negedge clk); n++; end
      checks++;
      if (filt_data_in !== samp(i)) begin
        errors++; $display("FAIL sweep_data_in[%0d]: got %h expected %h", i, filt_data_in, samp(i));
      end
      if (i < 199) send_src(samp(i + 1));
      n = 0;
      while (!out_valid && n < 40) begin @(negedge clk); n++; end
      if (i == 199) enable = 1'b0;
      if (out_valid) nvalid++;
      checks++;
      if (out_data !== (samp(i) ^ 24'h00F0F0)) begin
        errors++; $display("FAIL sweep_out[%0d]: got %h expected %h", i, out_data, samp(i) ^ 24'h00F0F0);
      end
    end
    @(negedge clk);
    checks++;
    if (nvalid !== 200 || sample_cnt !== 16'd200) begin
      errors++; $display("FAIL sweep_count: got %0d/%0d expected 200/200", nvalid, sample_cnt);
    end
    checks++;
    if ({overrun, underrun, timeout_err} !== 3'b000) begin
      errors++; $display("FAIL sweep_flags: got %b expected 000", {overrun, underrun, timeout_err});
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_overrun();
    test_underrun_timeout();
    test_simultaneous();
    test_reset_mid_wait();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
